// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the matrix scan sequencer: FSM state encoding
// and the width helper used to size the settle counter.
package matrix_scan_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETTLE   = 3'd1;
    localparam logic [2:0] ST_CONVERT  = 3'd2;
    localparam logic [2:0] ST_WAIT_ADC = 3'd3;
    localparam logic [2:0] ST_OUTPUT   = 3'd4;
    localparam logic [2:0] ST_ADVANCE  = 3'd5;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// ADC conversion handshake and downstream pixel handshake of the matrix
// scan sequencer. master = sequencer side, slave = ADC/sink side.
interface matrix_scan_ctrl_if #(
    parameter int unsigned Width     = 5,
    parameter int unsigned DataWidth = 12
);
    logic                 adc_start_o;
    logic                 adc_done_i;
    logic [DataWidth-1:0] adc_data_i;
    logic                 pix_valid_o;
    logic                 pix_ready_i;
    logic [DataWidth-1:0] pix_data_o;
    logic [Width-1:0]     pix_col_o;
    logic [Width-1:0]     pix_row_o;

    modport master (
        output adc_start_o,
        input  adc_done_i,
        input  adc_data_i,
        output pix_valid_o,
        input  pix_ready_i,
        output pix_data_o,
        output pix_col_o,
        output pix_row_o
    );

    modport slave (
        input  adc_start_o,
        output adc_done_i,
        output adc_data_i,
        input  pix_valid_o,
        output pix_ready_i,
        input  pix_data_o,
        input  pix_col_o,
        input  pix_row_o
    );
endinterface

// File: rtl/matrix_scan_ctrl_settle_timer.sv
// Mux settling timer: loading starts a window of SettleCycles clocks;
// done_o is high in the last clock of that window (and while idle).
module scan_settle_timer
    import matrix_scan_pkg::*;
#(
    parameter int unsigned SettleCycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic done_o
);
    localparam int unsigned CntW = cnt_width(SettleCycles + 1);
    localparam logic [CntW-1:0] LoadVal =
        (SettleCycles == 0) ? '0 : CntW'(SettleCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-major frame sequencer for the microbolometer mux matrix: selects a
// pixel, waits for settling, runs one ADC conversion and hands the tagged
// sample downstream. Optional macro CONTINUOUS_SCAN_EN makes the frame
// restart at (0,0) without start_i after the last pixel.
module matrix_scan_ctrl
    import matrix_scan_pkg::*;
#(
    parameter int unsigned Rows         = 2,
    parameter int unsigned Cols         = 2,
    parameter int unsigned Width        = 5,
    parameter int unsigned SettleCycles = 16,
    parameter int unsigned DataWidth    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [Width-1:0] col_sel_o,
    output logic [Width-1:0] row_sel_o,
    output logic             col_en_o,
    output logic             row_en_o,
    output logic             busy_o,
    output logic             frame_done_o,
    matrix_scan_ctrl_if.master bus
);
    localparam logic [Width-1:0] LastCol = Width'(Cols - 1);
    localparam logic [Width-1:0] LastRow = Width'(Rows - 1);
    // Per-pixel entry state: skip SETTLE entirely when no settling is needed.
    localparam logic [2:0] PixStart = (SettleCycles == 0) ? ST_CONVERT : ST_SETTLE;
    localparam logic       UseSettle = (SettleCycles != 0);

    logic [2:0]           state_q, state_d;
    logic [Width-1:0]     col_q, col_d;
    logic [Width-1:0]     row_q, row_d;
    logic [DataWidth-1:0] pix_data_q, pix_data_d;
    logic [Width-1:0]     pix_col_q, pix_col_d;
    logic [Width-1:0]     pix_row_q, pix_row_d;
    logic                 settle_load;
    logic                 settle_done;
    logic                 in_adv;
    logic                 col_last;
    logic                 row_last;

    scan_settle_timer #(
        .SettleCycles(SettleCycles)
    ) u_settle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(settle_load),
        .done_o(settle_done)
    );

    assign in_adv   = (state_q == ST_ADVANCE);
    assign col_last = (col_q == LastCol);
    assign row_last = (row_q == LastRow);

    // Next-state, index and sample-capture logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_data_d  = pix_data_q;
        pix_col_d   = pix_col_q;
        pix_row_d   = pix_row_q;
        settle_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = PixStart;
                    settle_load = UseSettle;
                end
            end
            ST_SETTLE: begin
                if (settle_done) state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                state_d = ST_WAIT_ADC;
            end
            ST_WAIT_ADC: begin
                if (bus.adc_done_i) begin
                    pix_data_d = bus.adc_data_i;
                    pix_col_d  = col_q;
                    pix_row_d  = row_q;
                    state_d    = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.pix_ready_i) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                state_d     = PixStart;
                settle_load = UseSettle;
                if (!col_last) begin
                    col_d = col_q + Width'(1);
                end else if (!row_last) begin
                    col_d = '0;
                    row_d = row_q + Width'(1);
                end else begin
                    col_d = '0;
                    row_d = '0;
`ifdef CONTINUOUS_SCAN_EN
                    state_d     = PixStart;
                    settle_load = UseSettle;
`else
                    state_d     = ST_IDLE;
                    settle_load = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and sample registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            pix_data_q <= '0;
            pix_col_q  <= '0;
            pix_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pix_data_q <= pix_data_d;
            pix_col_q  <= pix_col_d;
            pix_row_q  <= pix_row_d;
        end
    end

    assign col_sel_o       = col_q;
    assign row_sel_o       = row_q;
    assign col_en_o        = in_adv && !col_last;
    assign row_en_o        = in_adv && col_last && !row_last;
    assign frame_done_o    = in_adv && col_last && row_last;
    assign busy_o          = (state_q != ST_IDLE);
    assign bus.adc_start_o = (state_q == ST_CONVERT);
    assign bus.pix_valid_o = (state_q == ST_OUTPUT);
    assign bus.pix_data_o  = pix_data_q;
    assign bus.pix_col_o   = pix_col_q;
    assign bus.pix_row_o   = pix_row_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: dut_a uses 16 settle cycles,
// dut_b uses no settling. Both scan a 2x2 matrix.
module tb_matrix_scan_ctrl;
    import matrix_scan_pkg::*;

`ifdef CONTINUOUS_SCAN_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic       start_a, start_b;
    logic [4:0] col_sel_a, row_sel_a, col_sel_b, row_sel_b;
    logic       col_en_a, row_en_a, busy_a, frame_done_a;
    logic       col_en_b, row_en_b, busy_b, frame_done_b;

    matrix_scan_ctrl_if #(.Width(5), .DataWidth(12)) bus_a ();
    matrix_scan_ctrl_if #(.Width(5), .DataWidth(12)) bus_b ();

    matrix_scan_ctrl #(
        .Rows(2), .Cols(2), .Width(5), .SettleCycles(16), .DataWidth(12)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .col_sel_o(col_sel_a), .row_sel_o(row_sel_a),
        .col_en_o(col_en_a), .row_en_o(row_en_a),
        .busy_o(busy_a), .frame_done_o(frame_done_a),
        .bus(bus_a.master)
    );

    matrix_scan_ctrl #(
        .Rows(2), .Cols(2), .Width(5), .SettleCycles(0), .DataWidth(12)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .col_sel_o(col_sel_b), .row_sel_o(row_sel_b),
        .col_en_o(col_en_b), .row_en_o(row_en_b),
        .busy_o(busy_b), .frame_done_o(frame_done_b),
        .bus(bus_b.master)
    );

    // Pulse counters on dut_a, compared as differences against snapshots.
    int n_start_a = 0, n_colen_a = 0, n_rowen_a = 0, n_frame_a = 0, n_acc_a = 0;
    always @(posedge clk) begin
        if (bus_a.adc_start_o) n_start_a++;
        if (col_en_a) n_colen_a++;
        if (row_en_a) n_rowen_a++;
        if (frame_done_a) n_frame_a++;
        if (bus_a.pix_valid_o && bus_a.pix_ready_i) n_acc_a++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel on dut_a, entered in its first SETTLE cycle.
    task automatic pixel_a(input logic [4:0] r, input logic [4:0] c, input logic [11:0] data,
                           input int stall, input logic poke, input logic last);
        int s0, e0;
        s0 = n_start_a;
        chk("sel_col", col_sel_a, c);
        chk("sel_row", row_sel_a, r);
        chk("busy_settle", busy_a, 1);
        repeat (7) tick;
        if (poke) begin
            start_a = 1'b1;
            tick;
            start_a = 1'b0;
        end else begin
            tick;
        end
        repeat (7) tick;
        chk("settle_len", bus_a.adc_start_o, 0);
        tick;
        chk("adc_start", bus_a.adc_start_o, 1);
        repeat (4) tick;
        chk("wait_start", bus_a.adc_start_o, 0);
        chk("wait_valid", bus_a.pix_valid_o, 0);
        bus_a.adc_done_i  = 1'b1;
        bus_a.adc_data_i  = data;
        bus_a.pix_ready_i = (stall == 0);
        tick;
        bus_a.adc_done_i = 1'b0;
        bus_a.adc_data_i = ~data;
        chk("out_valid", bus_a.pix_valid_o, 1);
        chk("out_data", bus_a.pix_data_o, data);
        chk("out_col", bus_a.pix_col_o, c);
        chk("out_row", bus_a.pix_row_o, r);
        e0 = n_colen_a;
        for (int i = 0; i < stall; i++) begin
            tick;
            chk("stall_valid", bus_a.pix_valid_o, 1);
            chk("stall_data", bus_a.pix_data_o, data);
            chk("stall_col", bus_a.pix_col_o, c);
            chk("stall_start", bus_a.adc_start_o, 0);
            chk("stall_col_en", col_en_a, 0);
        end
        if (stall > 0) chk("stall_col_en_cnt", n_colen_a - e0, 0);
        bus_a.pix_ready_i = 1'b1;
        tick;
        chk("adv_valid", bus_a.pix_valid_o, 0);
        chk("adv_col_en", col_en_a, (c == 5'd0) ? 1 : 0);
        chk("adv_row_en", row_en_a, (c == 5'd1 && r == 5'd0) ? 1 : 0);
        chk("adv_frame_done", frame_done_a, last);
        tick;
        chk("next_col", col_sel_a, (c == 5'd0) ? 1 : 0);
        chk("next_row", row_sel_a, (c == 5'd0) ? r : ((r == 5'd0) ? 1 : 0));
        chk("busy_next", busy_a, last ? CONT : 1'b1);
        chk("one_start", n_start_a - s0, 1);
    endtask

    initial begin
        int b_fr, b_acc, b_col, b_row;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.adc_done_i = 1'b0; bus_a.adc_data_i = '0; bus_a.pix_ready_i = 1'b0;
        bus_b.adc_done_i = 1'b0; bus_b.adc_data_i = '0; bus_b.pix_ready_i = 1'b1;

        // Reset state
        repeat (2) tick;
        chk("rst_busy", busy_a, 0);
        chk("rst_col", col_sel_a, 0);
        chk("rst_row", row_sel_a, 0);
        chk("rst_valid", bus_a.pix_valid_o, 0);
        chk("rst_adc_start", bus_a.adc_start_o, 0);
        chk("rst_data", bus_a.pix_data_o, 0);
        chk("rst_frame_done", frame_done_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        bus_a.pix_ready_i = 1'b1;
        tick;
        chk("idle_ready_no_valid", bus_a.pix_valid_o, 0);
        chk("idle_busy", busy_a, 0);

        // dut_b: no settling, conversion follows start and each ADVANCE directly
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("b_start_lat", bus_b.adc_start_o, 1);
        for (int p = 0; p < 4; p++) begin
            chk("b_conv", bus_b.adc_start_o, 1);
            chk("b_col", col_sel_b, p % 2);
            chk("b_row", row_sel_b, p / 2);
            tick;
            chk("b_start_pulse", bus_b.adc_start_o, 0);
            bus_b.adc_done_i = 1'b1;
            bus_b.adc_data_i = 12'h100 + 12'(p);
            tick;
            bus_b.adc_done_i = 1'b0;
            chk("b_valid", bus_b.pix_valid_o, 1);
            chk("b_data", bus_b.pix_data_o, 12'h100 + 12'(p));
            tick;
            chk("b_adv_frame_done", frame_done_b, (p == 3) ? 1 : 0);
            tick;
        end
        chk("b_end_start", bus_b.adc_start_o, CONT);
        chk("b_end_busy", busy_b, CONT);

        // dut_a: full frame with a stall, a mid-frame start and a marked sample
        b_fr = n_frame_a; b_acc = n_acc_a; b_col = n_colen_a; b_row = n_rowen_a;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        pixel_a(5'd0, 5'd0, 12'h123, 0, 1'b0, 1'b0);
        pixel_a(5'd0, 5'd1, 12'h456, 10, 1'b0, 1'b0);
        pixel_a(5'd1, 5'd0, 12'hABC, 0, 1'b1, 1'b0);
        pixel_a(5'd1, 5'd1, 12'h789, 0, 1'b0, 1'b1);
`ifdef CONTINUOUS_SCAN_EN
        for (int f = 0; f < 2; f++) begin
            pixel_a(5'd0, 5'd0, 12'h210, 0, 1'b0, 1'b0);
            pixel_a(5'd0, 5'd1, 12'h321, 0, 1'b0, 1'b0);
            pixel_a(5'd1, 5'd0, 12'h432, 0, 1'b0, 1'b0);
            pixel_a(5'd1, 5'd1, 12'h543, 0, 1'b0, 1'b1);
        end
        chk("frames", n_frame_a - b_fr, 3);
        chk("samples", n_acc_a - b_acc, 12);
        chk("col_en_cnt", n_colen_a - b_col, 6);
        chk("row_en_cnt", n_rowen_a - b_row, 3);
`else
        chk("frames", n_frame_a - b_fr, 1);
        chk("samples", n_acc_a - b_acc, 4);
        chk("col_en_cnt", n_colen_a - b_col, 2);
        chk("row_en_cnt", n_rowen_a - b_row, 1);
        tick;
        chk("stays_idle", busy_a, 0);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
`endif

        // Reset while waiting on the ADC
        repeat (16) tick;
        chk("pre_rst_conv", bus_a.adc_start_o, 1);
        tick;
        chk("pre_rst_busy", busy_a, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_start", bus_a.adc_start_o, 0);
        chk("arst_valid", bus_a.pix_valid_o, 0);
        chk("arst_data", bus_a.pix_data_o, 0);
        chk("arst_col", col_sel_a, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_idle", busy_a, 0);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        pixel_a(5'd0, 5'd0, 12'h5A5, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
